// File: rtl/vip_stream_core_gen_pkg.sv
// Shared types and constants for the VIP stream core: FSM states, transform
// mode encodings and the greyscale luma coefficients.
package vip_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CTRL  = 2'd1,
        VID   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_GREY = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;

    // Weights sum to 256, so the >>8 result always fits in one symbol.
    localparam int unsigned COEF_R = 77;
    localparam int unsigned COEF_G = 150;
    localparam int unsigned COEF_B = 29;

endpackage

// File: rtl/vip_stream_core_gen_fifo.sv
// Synchronous FIFO with occupancy count; storage is reset so the head word
// reads as zero after reset.
module vip_sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vip_stream_core_gen.sv
// VIP stream core: control forwarding, per-beat transform pipeline and output
// FIFO. Optional VIP_FRAME_CHECK_EN adds the frame_err beat-count checker.
module vip_stream_core_gen
    import vip_core_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int LATENCY          = 2,
    parameter int FIFO_DEPTH       = 32,
    parameter int DEF_WIDTH        = 1920,
    parameter int DEF_HEIGHT       = 1080
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [1:0]                                  mode,
    input  logic                                        stall_in,
    output logic                                        read,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
    input  logic                                        end_of_video,
    input  logic [15:0]                                 width_in,
    input  logic [15:0]                                 height_in,
    input  logic [3:0]                                  interlaced_in,
    input  logic                                        vip_ctrl_valid,
    input  logic                                        stall_out,
    output logic                                        write,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
    output logic                                        end_of_video_out,
    output logic [15:0]                                 width_out,
    output logic [15:0]                                 height_out,
    output logic [3:0]                                  interlaced_out,
    input  logic                                        vip_ctrl_busy,
    output logic                                        vip_ctrl_send,
    output logic                                        busy
`ifdef VIP_FRAME_CHECK_EN
    ,
    output logic                                        frame_err
`endif
);
    localparam int BPS = BITS_PER_SYMBOL;
    localparam int W   = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic [1:0]    mode_q;
    logic [15:0]   width_q, height_q;
    logic [3:0]    intl_q;
    logic          rd_raw, rd_vid, credit_ok;
    logic [CW-1:0] inflight_q, fifo_count, used;
    logic          fifo_empty, fifo_full, push;
    logic [W:0]    head;
    logic          head_eov;

    // ---------------- transform ----------------
    logic [W-1:0]   inv_beat, grey_beat, xf_beat;
    logic [BPS-1:0] y;

    if (SYMBOLS_PER_BEAT >= 3) begin : g_luma
        logic [BPS+7:0] y_sum;
        assign y_sum = (BPS+8)'(data_in[2*BPS +: BPS]) * (BPS+8)'(COEF_R)
                     + (BPS+8)'(data_in[1*BPS +: BPS]) * (BPS+8)'(COEF_G)
                     + (BPS+8)'(data_in[0*BPS +: BPS]) * (BPS+8)'(COEF_B);
        assign y = y_sum[BPS+7:8];
    end else begin : g_noluma
        assign y = data_in[BPS-1:0];
    end

    for (genvar s = 0; s < SYMBOLS_PER_BEAT; s++) begin : g_sym
        assign inv_beat[s*BPS +: BPS] = ~data_in[s*BPS +: BPS];
        if (s < 3) begin : g_y
            assign grey_beat[s*BPS +: BPS] = y;
        end else begin : g_keep
            assign grey_beat[s*BPS +: BPS] = data_in[s*BPS +: BPS];
        end
    end

    always_comb begin
        xf_beat = data_in;
        case (mode_q)
            MODE_GREY: xf_beat = grey_beat;
            MODE_INV:  xf_beat = inv_beat;
            default:   xf_beat = data_in;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        rd_raw        = 1'b0;
        vip_ctrl_send = 1'b0;
        case (state_q)
            IDLE: begin
                rd_raw = ~stall_in & ~vip_ctrl_busy;
                if (vip_ctrl_valid) state_d = CTRL;
            end
            CTRL: begin
                vip_ctrl_send = 1'b1;
                if (~vip_ctrl_busy) state_d = VID;
            end
            VID: begin
                rd_raw = ~stall_in & credit_ok;
                if (rd_raw & end_of_video) state_d = DRAIN;
            end
            DRAIN: begin
                if (write & head_eov) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign read   = rd_raw & ~rst;
    assign rd_vid = read & (state_q == VID);

    // Credit covers beats still in the pipeline so a push can never hit a full FIFO.
    assign used      = fifo_count + inflight_q;
    assign credit_ok = (used < CW'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_PASS;
            width_q  <= 16'(DEF_WIDTH);
            height_q <= 16'(DEF_HEIGHT);
            intl_q   <= '0;
        end else if (state_q == IDLE && vip_ctrl_valid) begin
            mode_q   <= mode;
            width_q  <= width_in;
            height_q <= height_in;
            intl_q   <= interlaced_in;
        end
    end

    assign width_out      = width_q;
    assign height_out     = height_q;
    assign interlaced_out = intl_q;

    // ---------------- pipeline ----------------
    logic [LATENCY:1] vld_pipe_q;
    logic [W:0]       pipe_q [LATENCY:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            for (int i = 1; i <= LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            vld_pipe_q[1] <= rd_vid;
            pipe_q[1]     <= {end_of_video, xf_beat};
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                pipe_q[i]     <= pipe_q[i-1];
            end
        end
    end

    assign push = vld_pipe_q[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_q <= '0;
        else     inflight_q <= inflight_q + CW'(rd_vid) - CW'(push);
    end

    // ---------------- output FIFO ----------------
    vip_sync_fifo #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push & ~fifo_full),
        .din_i   (pipe_q[LATENCY]),
        .pop_i   (write),
        .dout_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_eov         = head[W];
    assign write            = ~fifo_empty & ~stall_out;
    assign data_out         = head[W-1:0];
    assign end_of_video_out = write & head_eov;
    assign busy             = (state_q != IDLE) | (inflight_q != '0) | ~fifo_empty;

`ifdef VIP_FRAME_CHECK_EN
    logic [31:0] beat_cnt_q, beat_nx, frame_px;
    logic        frame_err_q;

    assign frame_px = {16'd0, width_q} * {16'd0, height_q};
    assign beat_nx  = beat_cnt_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else if (write) begin
            if (head_eov) begin
                beat_cnt_q <= '0;
                if (beat_nx != frame_px) frame_err_q <= 1'b1;
            end else begin
                beat_cnt_q <= beat_nx;
                if (beat_nx == frame_px) frame_err_q <= 1'b1;
            end
        end
    end

    assign frame_err = frame_err_q;
`endif

endmodule
